// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
//   mult_state_t : FSM encoding (IDLE, RUN, DONE)
//   MULT_WIDTH   : default operand width
//   MULT_CNT_W   : iteration counter width for the default operand width
//   msb_index    : index of the highest set bit (0 for a zero value)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH + 1);

  function automatic int unsigned msb_index(input logic [63:0] value);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cla_adder_nbit.sv
// WIDTH-bit combinational adder built as a ripple chain of 2-bit carry-lookahead cells.
// Ports:
//   i_a, i_b : WIDTH-bit addends
//   i_cin    : carry in
//   o_sum    : WIDTH-bit sum
//   o_cout   : carry out of the top cell
// WIDTH must be even and >= 2.
module cla_adder_nbit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned NumCells = WIDTH / 2;

  logic [NumCells:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < NumCells; i++) begin : g_cell
    logic w_g0, w_p0, w_g1, w_p1, w_c1;

    assign w_g0 = i_a[2*i]   & i_b[2*i];
    assign w_p0 = i_a[2*i]   ^ i_b[2*i];
    assign w_g1 = i_a[2*i+1] & i_b[2*i+1];
    assign w_p1 = i_a[2*i+1] ^ i_b[2*i+1];

    // Both carries are computed directly from the cell's carry in.
    assign w_c1         = w_g0 | (w_p0 & w_carry[i]);
    assign w_carry[i+1] = w_g1 | (w_p1 & w_g0) | (w_p1 & w_p0 & w_carry[i]);

    assign o_sum[2*i]   = w_p0 ^ w_carry[i];
    assign o_sum[2*i+1] = w_p1 ^ w_c1;
  end

  assign o_cout = w_carry[NumCells];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier (MULT/MULTU datapath), one multiplier bit per cycle.
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   start        : request a multiply; accepted only in IDLE or DONE
//   multiplicand : operand A, captured on accepted start
//   multiplier   : operand B, captured on accepted start
//   busy         : high while in RUN
//   done         : high for the single DONE cycle
//   product      : {HI,LO}; held from done until the next result
// Build option MULT_EARLY_TERM_EN: finish as soon as the unconsumed multiplier bits are all zero.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Same value as MULT_CNT_W when WIDTH == MULT_WIDTH.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  mult_state_t          r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [WIDTH-1:0]     r_mcand, w_mcand_next;
  logic [2*WIDTH-1:0]   r_p, w_p_next;
  logic [2*WIDTH-1:0]   r_product, w_product_next;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_p_step;
  logic [2*WIDTH-1:0]   w_p_final;
  logic                 w_last;

  assign w_addend = r_p[0] ? r_mcand : '0;

  cla_adder_nbit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_p[2*WIDTH-1:WIDTH]),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry-out lands in the top bit, so the product can never overflow.
  assign w_p_step = {w_cout, w_sum, r_p[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
  logic [WIDTH:0]    w_one;
  logic [WIDTH:0]    w_mask;
  logic [CntW-1:0]   w_cnt_dec;
  logic              w_rest_zero;

  assign w_one     = {{WIDTH{1'b0}}, 1'b1};
  assign w_mask    = (w_one << r_cnt) - w_one;
  assign w_cnt_dec = r_cnt - CntW'(1);
  // Bits still waiting after the one consumed this cycle; if none are set, the remaining
  // iterations would only add zero and shift, so collapse them into one shift.
  assign w_rest_zero = ~|(r_p[WIDTH-1:1] & w_mask[WIDTH-1:1]);
  assign w_last      = w_rest_zero;
  assign w_p_final   = w_p_step >> w_cnt_dec;
`else
  assign w_last    = (r_cnt == CntW'(1));
  assign w_p_final = w_p_step;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_mcand_next   = r_mcand;
    w_p_next       = r_p;
    w_product_next = r_product;
    busy           = 1'b0;
    done           = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_mcand_next = multiplicand;
          w_p_next     = {{WIDTH{1'b0}}, multiplier};
          w_cnt_next   = CntW'(WIDTH);
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next   = DONE;
          w_p_next       = w_p_final;
          w_product_next = w_p_final;
          w_cnt_next     = '0;
        end else begin
          w_p_next   = w_p_step;
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_next = RUN;
          w_mcand_next = multiplicand;
          w_p_next     = {{WIDTH{1'b0}}, multiplier};
          w_cnt_next   = CntW'(WIDTH);
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_p       <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_mcand   <= w_mcand_next;
      r_p       <= w_p_next;
      r_product <= w_product_next;
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: an 8-bit instance for the directed cases and
// a 32-bit instance for a randomised product sweep. Expectations follow MULT_EARLY_TERM_EN.
module tb_seq_shift_add_multiplier;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic        start32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] prod32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (a8),
    .multiplier   (b8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  seq_shift_add_multiplier #(.WIDTH(32)) dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start32),
    .multiplicand (a32),
    .multiplier   (b32),
    .busy         (busy32),
    .done         (done32),
    .product      (prod32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of RUN cycles expected for a given multiplier.
  function automatic int exp_runs(input logic [31:0] b, input int w);
    int m;
    m = 0;
    for (int i = 0; i < w; i++) begin
      if (b[i]) m = i + 1;
    end
    if (!EarlyTerm) return w;
    return (m == 0) ? 1 : m;
  endfunction

  // Called at a negedge; start is sampled at the following posedge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    a8    = a;
    b8    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until DONE; optionally pulses start (5*5) at busy cycle 'poke'.
  task automatic wait_done(input string tag, input logic [15:0] exp, input int runs_exp,
                           input int poke);
    int runs;
    runs = 0;
    while (busy8 && runs < 200) begin
      runs++;
      if (poke != 0 && runs == poke) begin
        start = 1'b1;
        a8    = 8'd5;
        b8    = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_runs"}, 64'(runs), 64'(runs_exp));
    check({tag, "_done"}, 64'(done8), 64'd1);
    check({tag, "_prod"}, 64'(prod8), 64'(exp));
  endtask

  task automatic go_idle(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done8), 64'd0);
    check({tag, "_idle"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    int runs;
    logic [63:0] exp64;

    reset_n = 1'b0;
    start   = 1'b0;
    start32 = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_prod", 64'(prod8), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic
    start_op(8'd13, 8'd11);
    check("basic_busy", 64'(busy8), 64'd1);
    wait_done("basic", 16'd143, exp_runs(32'd11, 8), 0);
    go_idle("basic");

    // Max operands
    start_op(8'd255, 8'd255);
    wait_done("max", 16'd65025, exp_runs(32'd255, 8), 0);
    go_idle("max");

    // Zero operands
    start_op(8'd0, 8'd77);
    wait_done("zero_a", 16'd0, exp_runs(32'd77, 8), 0);
    go_idle("zero_a");
    start_op(8'd77, 8'd0);
    wait_done("zero_b", 16'd0, exp_runs(32'd0, 8), 0);
    go_idle("zero_b");

    // start mid-RUN ignored
    start_op(8'd9, 8'd10);
    wait_done("ignore", 16'd90, exp_runs(32'd10, 8), 2);
    go_idle("ignore");

    // Back-to-back: start during DONE is accepted, product held until new done
    start_op(8'd3, 8'd4);
    wait_done("b2b1", 16'd12, exp_runs(32'd4, 8), 0);
    start_op(8'd6, 8'd7);
    check("b2b_accept", 64'(busy8), 64'd1);
    check("b2b_hold", 64'(prod8), 64'd12);
    wait_done("b2b2", 16'd42, exp_runs(32'd7, 8), 0);
    go_idle("b2b2");

    // Reset mid-RUN
    start_op(8'd13, 8'd200);
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(busy8), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy8), 64'd0);
    check("mid_rst_done", 64'(done8), 64'd0);
    check("mid_rst_prod", 64'(prod8), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 64'(done8), 64'd0);
    start_op(8'd13, 8'd200);
    wait_done("post_rst", 16'd2600, exp_runs(32'd200, 8), 0);
    go_idle("post_rst");

    // Short multiplier (two RUN cycles with early termination)
    start_op(8'd200, 8'd3);
    wait_done("short", 16'd600, exp_runs(32'd3, 8), 0);
    go_idle("short");

    // 32-bit sweep against A*B
    for (int n = 0; n < 16; n++) begin
      a32 = $urandom;
      b32 = $urandom >> $urandom_range(0, 31);
      if (n == 0) b32 = 32'd0;
      if (n == 1) b32 = 32'hFFFF_FFFF;
      if (n == 1) a32 = 32'hFFFF_FFFF;
      exp64   = {32'd0, a32} * {32'd0, b32};
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      runs = 0;
      while (busy32 && runs < 200) begin
        runs++;
        @(negedge clk);
      end
      check("w32_runs", 64'(runs), 64'(exp_runs(b32, 32)));
      check("w32_done", 64'(done32), 64'd1);
      check("w32_prod", prod32, exp64);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
